adder64_arbiter: RTL and testbench
==================================

# adder64_arbiter

Sequencing arbiter that shares one combinational 64-bit ripple-carry adder among NREQ requesters. It owns the adder's operand and carry-in inputs and grants requesters round-robin. It holds operands stable for a programmable settle window before capturing the sum. It also supports locked carry-chaining, so one requester can perform multi-word (128-bit and wider) additions without interleaving.

## Interface
- NREQ, 4: number of requesters; legal range is 2 or more. IW = $clog2(NREQ).
- WIDTH, 64: operand width; must match the attached adder.
- SETTLE, 2: number of clock edges operands are held at the adder before the sum is captured; legal range is 1 or more.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a, req_b  in  NREQ*WIDTH  operands; requester i occupies slice [i*WIDTH +: WIDTH].
- req_ci  in  NREQ  carry-in; ignored while a chain is active.
- req_chain  in  NREQ  1 means another chained word follows this one.
- add_a, add_b  out  WIDTH  registered operands driven to the adder.
- add_ci  out  1  registered carry-in driven to the adder.
- add_s  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out (c[WIDTH-1]).
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_sum  out  WIDTH  captured sum.
- rsp_cout  out  1  captured carry-out.
- rsp_id  out  IW  index of the requester that owns the result.
- busy  out  1  high when state is not IDLE or chain_active is set.

## Operation
- The FSM has three states: IDLE, SETTLE and RESP. Reset puts it in IDLE.
- **IDLE, arbitration**
  - Round-robin selection starts at rr_ptr and picks the first requester i with req_valid[i] set.
  - req_ready[i] is driven combinationally, only in IDLE, for the selected requester. The handshake is req_valid & req_ready.
  - While chain_active is set, only requester lock_id is eligible and other requesters are never granted.
- **On acceptance of requester g**
  - add_a and add_b load requester g's operands.
  - add_ci loads saved_cout if chain_active is set, otherwise req_ci[g].
  - rsp_id is set to g and cnt is set to SETTLE.
  - The FSM moves to SETTLE.
  - If req_chain[g] is 1: chain_active is set, lock_id becomes g, and rr_ptr is not changed.
  - If req_chain[g] is 0: chain_active is cleared and rr_ptr becomes (g+1) mod NREQ.
- **SETTLE**
  - cnt decrements on every edge.
  - On the edge where cnt equals 1: rsp_sum takes add_s, rsp_cout takes add_cout, saved_cout takes add_cout, rsp_valid is set, and the FSM moves to RESP.
- **RESP**
  - rsp_sum, rsp_cout and rsp_id are held stable while rsp_valid is high.
  - On rsp_valid & rsp_ready: rsp_valid is cleared and the FSM moves to IDLE.
  - No new request is accepted in the same cycle as this handshake.
- add_a, add_b and add_ci stay unchanged outside acceptance edges, so the adder inputs never glitch during SETTLE.
- req_chain=0 on the final word of a chain releases the lock. The final word itself still uses saved_cout as its carry-in.
- A lone request with req_chain=0 while no chain is active is an ordinary single add.
- Sum width is WIDTH bits, modulo 2^WIDTH. Overflow is reported only through rsp_cout.

## Timing
- **Reset values:** FSM in IDLE; rsp_valid=0; rsp_sum=0; rsp_cout=0; rsp_id=0; add_a=0; add_b=0; add_ci=0; req_ready=0; busy=0; rr_ptr=0; chain_active=0; saved_cout=0; cnt=0.
- **Latency:** acceptance on edge E0 leads to capture on edge E0+SETTLE. rsp_valid is high from the cycle after capture.
- **Throughput:** with rsp_ready held high, one operation every SETTLE+2 cycles.
- **Back-pressure:** rsp_ready=0 holds the FSM in RESP indefinitely with all outputs stable. Requests are not accepted during this time.
- **Simultaneous requests:** exactly one grant per IDLE cycle, chosen by the rr_ptr order.
- **Withdrawal:** a requester that drops req_valid without a handshake loses nothing. No state changes.
- **Chain stall:** while chain_active is set and the lock_id requester is not valid, the block waits in IDLE. It does not time out and does not grant other requesters.
- **Reset mid-operation:** reset may assert in any state. It takes effect asynchronously and all reset values apply immediately. This includes dropping the lock and any in-flight result.

## Test plan
- **Single add:** with SETTLE=2, req0 sends a=5, b=7, ci=1, chain=0. Required: rsp_sum=13, rsp_cout=0 and rsp_id=0, with rsp_valid first high 2 edges after acceptance.
- **Overflow:** req1 sends a=0xFFFFFFFFFFFFFFFF, b=1, ci=0. Required: rsp_sum=0 and rsp_cout=1.
- **Round-robin fairness:** all 4 requesters hold valid and rsp_ready is held at 1. Required: grant order 0,1,2,3,0. Each grant is a single-bit req_ready, and grants are spaced SETTLE+2 cycles apart.
- **128-bit chain:**
  - req2 sends low word a=0xFFFFFFFFFFFFFFFF, b=1, chain=1, then high word a=0, b=0, ci=0 (ignored), chain=0.
  - Required: low result is 0 with cout=1 and high result is 1.
  - req3, held valid throughout, must not be granted until after the high word is accepted.
- **Back-pressure:** rsp_ready is held at 0 for 10 cycles after rsp_valid rises. Required: rsp_* stay stable, busy=1, and all req_ready bits stay 0. Releasing rsp_ready completes the handshake, and IDLE follows on the next cycle.
- **Reset mid-operation:** rst_n is asserted during SETTLE with a chain active. Required: all outputs return to their reset values immediately. After release, a req3 request is granted, rr_ptr has reset to 0, and carry-in comes from req_ci.

Source files
------------

// File: rtl/adder64_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : adder64_arbiter_if
// Purpose  : Bundles the requester, adder and response signals of the
//            shared-adder arbiter.
// Ports    : master - arbiter side (drives req_ready, add_*, rsp_*, busy)
//            slave  - environment side (requesters, adder, result consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface adder64_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
);
  localparam int IW = $clog2(NREQ);

  // Requester side
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ci;
  logic [NREQ-1:0]       req_chain;

  // Shared combinational adder
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_ci;
  logic [WIDTH-1:0]      add_s;
  logic                  add_cout;

  // Result side
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IW-1:0]         rsp_id;
  logic                  busy;

  modport master (
    input  req_valid, req_a, req_b, req_ci, req_chain, add_s, add_cout, rsp_ready,
    output req_ready, add_a, add_b, add_ci, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
  );

  modport slave (
    output req_valid, req_a, req_b, req_ci, req_chain, add_s, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, add_ci, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/adder64_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder64_arbiter
// Purpose  : Shares one combinational ripple-carry adder among NREQ
//            requesters. Round-robin grant, registered adder operands held
//            for SETTLE edges before the sum is captured, and locked
//            carry-chaining for multi-word additions.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - adder64_arbiter_if.master (requests, adder, response)
// Revision : 1.0 - initial release
// ============================================================================
module adder64_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 64,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  adder64_arbiter_if.master   bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t           state_q,        state_d;
  logic [WIDTH-1:0] add_a_q,        add_a_d;
  logic [WIDTH-1:0] add_b_q,        add_b_d;
  logic             add_ci_q,       add_ci_d;
  logic [WIDTH-1:0] rsp_sum_q,      rsp_sum_d;
  logic             rsp_cout_q,     rsp_cout_d;
  logic             rsp_valid_q,    rsp_valid_d;
  logic [IW-1:0]    rsp_id_q,       rsp_id_d;
  logic [IW-1:0]    rr_ptr_q,       rr_ptr_d;
  logic [IW-1:0]    lock_id_q,      lock_id_d;
  logic             chain_active_q, chain_active_d;
  logic             saved_cout_q,   saved_cout_d;
  logic [CW-1:0]    cnt_q,          cnt_d;

  logic             grant_vld;
  logic [IW-1:0]    grant_idx;
  logic [IW:0]      scan;
  logic [NREQ-1:0]  req_ready;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_ci;
  logic             sel_chain;

  // Arbitration: while a chain is locked only its owner may win; otherwise
  // scan from rr_ptr with wrap-around and take the first valid requester.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    if (chain_active_q) begin
      grant_vld = bus.req_valid[lock_id_q];
      grant_idx = lock_id_q;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
        if (scan >= (IW+1)'(NREQ)) begin
          scan = scan - (IW+1)'(NREQ);
        end
        if (!grant_vld && bus.req_valid[scan[IW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = scan[IW-1:0];
        end
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_ci    = 1'b0;
    sel_chain = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IW'(k)) begin
        sel_a     = bus.req_a[k*WIDTH +: WIDTH];
        sel_b     = bus.req_b[k*WIDTH +: WIDTH];
        sel_ci    = bus.req_ci[k];
        sel_chain = bus.req_chain[k];
      end
    end
  end

  assign accept = (state_q == ST_IDLE) && grant_vld;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d        = state_q;
    add_a_d        = add_a_q;
    add_b_d        = add_b_q;
    add_ci_d       = add_ci_q;
    rsp_sum_d      = rsp_sum_q;
    rsp_cout_d     = rsp_cout_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rr_ptr_d       = rr_ptr_q;
    lock_id_d      = lock_id_q;
    chain_active_d = chain_active_q;
    saved_cout_d   = saved_cout_q;
    cnt_d          = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          add_a_d  = sel_a;
          add_b_d  = sel_b;
          // Inside a chain the carry comes from the previous word's result
          add_ci_d = chain_active_q ? saved_cout_q : sel_ci;
          rsp_id_d = grant_idx;
          cnt_d    = CW'(SETTLE);
          state_d  = ST_SETTLE;
          if (sel_chain) begin
            chain_active_d = 1'b1;
            lock_id_d      = grant_idx;
          end else begin
            chain_active_d = 1'b0;
            rr_ptr_d       = (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + IW'(1);
          end
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rsp_sum_d    = bus.add_s;
          rsp_cout_d   = bus.add_cout;
          saved_cout_d = bus.add_cout;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      add_a_q        <= '0;
      add_b_q        <= '0;
      add_ci_q       <= 1'b0;
      rsp_sum_q      <= '0;
      rsp_cout_q     <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rr_ptr_q       <= '0;
      lock_id_q      <= '0;
      chain_active_q <= 1'b0;
      saved_cout_q   <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      add_a_q        <= add_a_d;
      add_b_q        <= add_b_d;
      add_ci_q       <= add_ci_d;
      rsp_sum_q      <= rsp_sum_d;
      rsp_cout_q     <= rsp_cout_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rr_ptr_q       <= rr_ptr_d;
      lock_id_q      <= lock_id_d;
      chain_active_q <= chain_active_d;
      saved_cout_q   <= saved_cout_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_ci    = add_ci_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state_q != ST_IDLE) || chain_active_q;

endmodule
`default_nettype wire

// File: tb/tb_adder64_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder64_arbiter
// Purpose  : Self-checking bench for adder64_arbiter with a behavioural
//            64-bit adder attached to the interface and a transaction-level
//            reference model for grants, carries and sums.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder64_arbiter;
  localparam int NREQ   = 4;
  localparam int WIDTH  = 64;
  localparam int SETTLE = 2;
  localparam int LIMIT  = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder64_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

  adder64_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The shared adder
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{WIDTH{1'b0}}, bus.add_ci};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, input logic chain, input logic vld);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_ci[i]    = ci;
    bus.req_chain[i] = chain;
    bus.req_valid[i] = vld;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_ci    = '0;
    bus.req_chain = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with inputs already applied; returns at negedge+1
  task automatic wait_grant(output int id, output bit ok);
    id = -1;
    ok = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      #1;
      if (bus.req_ready != '0) begin
        ok = 1'b1;
        for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) id = j;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Counts negedges until rsp_valid is seen
  task automatic wait_rsp(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      #1;
      lat++;
      if (bus.rsp_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_sum !== '0) begin n_fail++; $display("FAIL reset_rsp_sum got %h want 0", bus.rsp_sum); end
    n_checks++; if ({bus.rsp_cout, bus.rsp_id} !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_cout_id got %b want 000", {bus.rsp_cout, bus.rsp_id}); end
    n_checks++; if ({bus.add_a, bus.add_b, bus.add_ci} !== '0) begin n_fail++; $display("FAIL reset_add_ops got %h/%h/%b want 0", bus.add_a, bus.add_b, bus.add_ci); end
    n_checks++; if ({bus.req_ready, bus.busy} !== 5'b0) begin n_fail++; $display("FAIL reset_ready_busy got %b want 0", {bus.req_ready, bus.busy}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [WIDTH-1:0] ra[NREQ];
    logic [WIDTH-1:0] rb[NREQ];
    logic             rc[NREQ];
    logic [WIDTH:0]   e;
    int id, lat, last;
    bit ok;
    last = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = {$urandom, $urandom};
      rb[i] = {$urandom, $urandom};
      rc[i] = 1'($urandom_range(0, 1));
      set_req(i, ra[i], rb[i], rc[i], 1'b0, 1'b1);
    end
    for (int t = 0; t < 5; t++) begin
      wait_grant(id, ok);
      n_checks++; if (!ok || id != exp_order[t]) begin n_fail++; $display("FAIL rr_grant[%0d] got %0d want %0d", t, id, exp_order[t]); end
      n_checks++; if (!$onehot(bus.req_ready)) begin n_fail++; $display("FAIL rr_onehot[%0d] got %b want one-hot", t, bus.req_ready); end
      if (t > 0) begin
        n_checks++; if (cyc - last != SETTLE + 2) begin n_fail++; $display("FAIL rr_spacing[%0d] got %0d want %0d", t, cyc - last, SETTLE + 2); end
      end
      last = cyc;
      e = {1'b0, ra[exp_order[t]]} + {1'b0, rb[exp_order[t]]} + {{WIDTH{1'b0}}, rc[exp_order[t]]};
      @(posedge clk); #1;
      if (t == 4) bus.req_valid = '0;
      wait_rsp(lat, ok);
      n_checks++; if (!ok || lat != SETTLE + 1) begin n_fail++; $display("FAIL rr_latency[%0d] got %0d want %0d", t, lat, SETTLE + 1); end
      n_checks++; if ({bus.rsp_cout, bus.rsp_sum} !== e) begin n_fail++; $display("FAIL rr_sum[%0d] got %h want %h", t, {bus.rsp_cout, bus.rsp_sum}, e); end
      n_checks++; if (int'(bus.rsp_id) != exp_order[t]) begin n_fail++; $display("FAIL rr_rsp_id[%0d] got %0d want %0d", t, bus.rsp_id, exp_order[t]); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_add();
    int id, lat;
    bit ok;
    clear_reqs();
    bus.rsp_ready = 1'b1;
    set_req(0, 64'd5, 64'd7, 1'b1, 1'b0, 1'b1);
    wait_grant(id, ok);
    n_checks++; if (!ok || id != 0) begin n_fail++; $display("FAIL single_grant got %0d want 0", id); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    n_checks++; if ({bus.add_a, bus.add_b, bus.add_ci} !== {64'd5, 64'd7, 1'b1}) begin n_fail++; $display("FAIL single_add_ops got %0d/%0d/%b want 5/7/1", bus.add_a, bus.add_b, bus.add_ci); end
    wait_rsp(lat, ok);
    n_checks++; if (!ok || lat != SETTLE + 1) begin n_fail++; $display("FAIL single_latency got %0d want %0d", lat, SETTLE + 1); end
    n_checks++; if (bus.rsp_sum !== 64'd13 || bus.rsp_cout !== 1'b0) begin n_fail++; $display("FAIL single_sum got %0d/%b want 13/0", bus.rsp_sum, bus.rsp_cout); end
    n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id got %0d want 0", bus.rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int id, lat;
    bit ok;
    clear_reqs();
    set_req(1, {WIDTH{1'b1}}, 64'd1, 1'b0, 1'b0, 1'b1);
    wait_grant(id, ok);
    n_checks++; if (!ok || id != 1) begin n_fail++; $display("FAIL ovf_grant got %0d want 1", id); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat, ok);
    n_checks++; if (!ok || bus.rsp_sum !== '0 || bus.rsp_cout !== 1'b1) begin n_fail++; $display("FAIL ovf_sum got %h/%b want 0/1", bus.rsp_sum, bus.rsp_cout); end
    n_checks++; if (bus.rsp_id !== 2'd1) begin n_fail++; $display("FAIL ovf_rsp_id got %0d want 1", bus.rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_chain128();
    int id, lat;
    bit ok;
    clear_reqs();
    bus.rsp_ready = 1'b1;
    pulse_reset();
    set_req(2, {WIDTH{1'b1}}, 64'd1, 1'b0, 1'b1, 1'b1);
    set_req(3, 64'd3, 64'd4, 1'b0, 1'b0, 1'b1);
    wait_grant(id, ok);
    n_checks++; if (!ok || id != 2) begin n_fail++; $display("FAIL chain_lo_grant got %0d want 2", id); end
    @(posedge clk); #1;
    set_req(2, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    wait_rsp(lat, ok);
    n_checks++; if (!ok || bus.rsp_sum !== '0 || bus.rsp_cout !== 1'b1) begin n_fail++; $display("FAIL chain_lo_sum got %h/%b want 0/1", bus.rsp_sum, bus.rsp_cout); end
    @(negedge clk);
    // Lock owner absent: req3 stays valid but must not be granted
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (bus.req_ready !== '0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL chain_stall[%0d] got ready=%b busy=%b want 0000/1", k, bus.req_ready, bus.busy); end
      @(negedge clk);
    end
    bus.req_valid[2] = 1'b1;
    wait_grant(id, ok);
    n_checks++; if (!ok || id != 2) begin n_fail++; $display("FAIL chain_hi_grant got %0d want 2", id); end
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    n_checks++; if (bus.add_ci !== 1'b1) begin n_fail++; $display("FAIL chain_hi_ci got %b want 1", bus.add_ci); end
    wait_rsp(lat, ok);
    n_checks++; if (!ok || bus.rsp_sum !== 64'd1 || bus.rsp_cout !== 1'b0) begin n_fail++; $display("FAIL chain_hi_sum got %h/%b want 1/0", bus.rsp_sum, bus.rsp_cout); end
    @(negedge clk);
    wait_grant(id, ok);
    n_checks++; if (!ok || id != 3) begin n_fail++; $display("FAIL chain_after_grant got %0d want 3", id); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat, ok);
    n_checks++; if (!ok || bus.rsp_sum !== 64'd7 || bus.rsp_id !== 2'd3) begin n_fail++; $display("FAIL chain_after_sum got %0d id %0d want 7 id 3", bus.rsp_sum, bus.rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [WIDTH:0]   e0, e1;
    int id, lat;
    bit ok;
    clear_reqs();
    bus.rsp_ready = 1'b0;
    a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    e0 = {1'b0, a0} + {1'b0, b0};
    e1 = {1'b0, a1} + {1'b0, b1} + 65'd1;
    set_req(0, a0, b0, 1'b0, 1'b0, 1'b1);
    wait_grant(id, ok);
    n_checks++; if (!ok || id != 0) begin n_fail++; $display("FAIL bp_grant got %0d want 0", id); end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    set_req(1, a1, b1, 1'b1, 1'b0, 1'b1);
    wait_rsp(lat, ok);
    n_checks++; if (!ok || {bus.rsp_cout, bus.rsp_sum} !== e0) begin n_fail++; $display("FAIL bp_sum got %h want %h", {bus.rsp_cout, bus.rsp_sum}, e0); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_cout, bus.rsp_sum, bus.rsp_id, bus.busy, bus.req_ready} !== {1'b1, e0, 2'd0, 1'b1, 4'b0000}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b s=%h id=%0d busy=%b rdy=%b want v=1 s=%h id=0 busy=1 rdy=0000",
                           k, bus.rsp_valid, {bus.rsp_cout, bus.rsp_sum}, bus.rsp_id, bus.busy, bus.req_ready, e0);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release got v=%b rdy=%b want 0/0010", bus.rsp_valid, bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat, ok);
    n_checks++; if (!ok || {bus.rsp_cout, bus.rsp_sum} !== e1 || bus.rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_next_sum got %h id %0d want %h id 1", {bus.rsp_cout, bus.rsp_sum}, bus.rsp_id, e1); end
    @(negedge clk);
  endtask

  // Random traffic against a transaction-level model of the arbitration rules
  task automatic test_random();
    logic [WIDTH-1:0] ra[NREQ];
    logic [WIDTH-1:0] rb[NREQ];
    logic             rc[NREQ];
    logic             rch[NREQ];
    logic [NREQ-1:0]  vmask;
    logic [WIDTH:0]   e;
    logic             eci;
    int  m_rr, m_lock, eg, id, lat;
    bit  m_chain, m_cout, ok;
    clear_reqs();
    bus.rsp_ready = 1'b1;
    pulse_reset();
    m_rr = 0; m_lock = 0; m_chain = 1'b0; m_cout = 1'b0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        ra[i]  = ($urandom_range(0, 3) == 0) ? {WIDTH{1'b1}} : {$urandom, $urandom};
        rb[i]  = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom};
        rc[i]  = 1'($urandom_range(0, 1));
        rch[i] = (t < 39) && ($urandom_range(0, 2) == 0);
      end
      vmask = 4'($urandom_range(1, 15));
      // Occasionally let the lock owner stall while others are valid
      if (m_chain && $urandom_range(0, 2) == 0) begin
        for (int i = 0; i < NREQ; i++) set_req(i, ra[i], rb[i], rc[i], rch[i], (i != m_lock));
        #1;
        n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL rand_stall[%0d] got %b want 0000", t, bus.req_ready); end
        @(negedge clk);
      end
      if (m_chain) vmask[m_lock] = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, ra[i], rb[i], rc[i], rch[i], vmask[i]);
      eg = -1;
      if (m_chain) eg = m_lock;
      else for (int k = 0; k < NREQ; k++) if (eg < 0 && vmask[(m_rr + k) % NREQ]) eg = (m_rr + k) % NREQ;
      wait_grant(id, ok);
      n_checks++; if (!ok || id != eg || !$onehot(bus.req_ready)) begin n_fail++; $display("FAIL rand_grant[%0d] got %0d (%b) want %0d", t, id, bus.req_ready, eg); end
      eci = m_chain ? m_cout : rc[eg];
      e   = {1'b0, ra[eg]} + {1'b0, rb[eg]} + {{WIDTH{1'b0}}, eci};
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = '0;
      wait_rsp(lat, ok);
      n_checks++; if (!ok || lat != SETTLE + 1) begin n_fail++; $display("FAIL rand_latency[%0d] got %0d want %0d", t, lat, SETTLE + 1); end
      n_checks++; if ({bus.rsp_cout, bus.rsp_sum} !== e || int'(bus.rsp_id) != eg) begin n_fail++; $display("FAIL rand_result[%0d] got %h id %0d want %h id %0d", t, {bus.rsp_cout, bus.rsp_sum}, bus.rsp_id, e, eg); end
      m_cout = e[WIDTH];
      if (rch[eg]) begin m_chain = 1'b1; m_lock = eg; end
      else begin m_chain = 1'b0; m_rr = (eg + 1) % NREQ; end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int id, lat;
    bit ok;
    clear_reqs();
    bus.rsp_ready = 1'b1;
    set_req(1, 64'd123, 64'd456, 1'b0, 1'b1, 1'b1);
    wait_grant(id, ok);
    n_checks++; if (!ok || id != 1) begin n_fail++; $display("FAIL rstmid_grant got %0d want 1", id); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id, bus.add_a, bus.add_b, bus.add_ci, bus.req_ready, bus.busy} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs got v=%b s=%h c=%b id=%0d a=%h b=%h ci=%b rdy=%b busy=%b want all 0",
                         bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id, bus.add_a, bus.add_b, bus.add_ci, bus.req_ready, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(3, 64'd10, 64'd20, 1'b1, 1'b0, 1'b1);
    wait_grant(id, ok);
    n_checks++; if (!ok || id != 3) begin n_fail++; $display("FAIL rstmid_req3_grant got %0d want 3", id); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    n_checks++; if (bus.add_ci !== 1'b1) begin n_fail++; $display("FAIL rstmid_ci got %b want 1", bus.add_ci); end
    wait_rsp(lat, ok);
    n_checks++; if (!ok || bus.rsp_sum !== 64'd31 || bus.rsp_id !== 2'd3) begin n_fail++; $display("FAIL rstmid_sum got %0d id %0d want 31 id 3", bus.rsp_sum, bus.rsp_id); end
    @(negedge clk);
    // Pointer advanced from 3 to 0: with 0 and 2 valid, 0 wins
    set_req(0, 64'd1, 64'd1, 1'b0, 1'b0, 1'b1);
    set_req(2, 64'd2, 64'd2, 1'b0, 1'b0, 1'b1);
    wait_grant(id, ok);
    n_checks++; if (!ok || id != 0) begin n_fail++; $display("FAIL rstmid_wrap_grant got %0d want 0", id); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat, ok);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    clear_reqs();
    test_reset();
    test_round_robin();
    test_single_add();
    test_overflow();
    test_chain128();
    test_back_pressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
